wdt_service_ctrl: RTL and testbench

WDT_SERVICE_CTRL -- requirements
Module: wdt_service_ctrl

---
 rtl/wdt_service_ctrl.sv | 136 +++++++++++++
 tb/tb_wdt_service_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wdt_service_ctrl.sv
`timescale 1ns/1ps
// Watchdog service controller: kicks an external watchdog only when every task
// has checked in during the current service window; otherwise latches a fault.
module wdt_service_ctrl #(
  parameter int KICK_PERIOD = 50,
  parameter int KICK_WIDTH  = 2,
  parameter int NTASK       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NTASK-1:0] alive,
  input  logic             wdt_rst_i,
  output logic             kick,
  output logic             fault,
  output logic [NTASK-1:0] miss_mask,
  output logic [7:0]       rst_seen,
  output logic [1:0]       state_o
);

  localparam int CW  = (KICK_PERIOD > 1) ? $clog2(KICK_PERIOD) : 1;
  localparam int KWW = (KICK_WIDTH > 1) ? $clog2(KICK_WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(KICK_PERIOD - 1);
  localparam logic [KWW-1:0] KW_LAST  = KWW'(KICK_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_KICK = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [KWW-1:0]   kw_q, kw_d;
  logic [NTASK-1:0] seen_q, seen_d;
  logic [NTASK-1:0] miss_q, miss_d;
  logic             fault_q, fault_d;
  logic             kick_q, kick_d;
  logic [7:0]       rs_q, rs_d;
  logic             wdt_rst_q;

  logic [NTASK-1:0] seen_now;
  logic             rst_rise;
  logic             eval;

  assign seen_now = seen_q | alive;
  assign rst_rise = wdt_rst_i & ~wdt_rst_q;
  assign eval     = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kw_d    = kw_q;
    seen_d  = seen_q;
    miss_d  = miss_q;
    fault_d = fault_q;
    rs_d    = rs_q;

    if (rst_rise && (rs_q != 8'hFF)) rs_d = rs_q + 8'd1;

    // Watchdog reset and disable both park the block with all window state cleared.
    if (wdt_rst_i || !en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      kw_d    = '0;
      seen_d  = '0;
      miss_d  = '0;
      fault_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_RUN;
          cnt_d   = '0;
          seen_d  = '0;
        end
        S_RUN, S_KICK: begin
          seen_d = seen_now;
          cnt_d  = eval ? '0 : cnt_q + CW'(1);
          if (state_q == S_KICK) begin
            kw_d = kw_q + KWW'(1);
            if (kw_q == KW_LAST) state_d = S_RUN;
          end
          if (eval) begin
            if (&seen_now) begin
              state_d = S_KICK;
              kw_d    = '0;
              seen_d  = '0;
            end else begin
              state_d = S_HOLD;
              fault_d = 1'b1;
              miss_d  = ~seen_now;
            end
          end
        end
        S_HOLD: begin
          state_d = S_HOLD;
        end
        default: state_d = S_IDLE;
      endcase
    end

    kick_d = (state_d == S_KICK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      kw_q      <= '0;
      seen_q    <= '0;
      miss_q    <= '0;
      fault_q   <= 1'b0;
      kick_q    <= 1'b0;
      rs_q      <= 8'd0;
      wdt_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      kw_q      <= kw_d;
      seen_q    <= seen_d;
      miss_q    <= miss_d;
      fault_q   <= fault_d;
      kick_q    <= kick_d;
      rs_q      <= rs_d;
      wdt_rst_q <= wdt_rst_i;
    end
  end

  assign kick      = kick_q;
  assign fault     = fault_q;
  assign miss_mask = miss_q;
  assign rst_seen  = rs_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_wdt_service_ctrl.sv
`timescale 1ns/1ps
// Directed bench for wdt_service_ctrl: table of single-window check-in patterns
// plus hand-written sequences for periodic kicks, HOLD exit, reset counting and rst mid-kick.
module tb_wdt_service_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] alive;
  logic       wdt_rst_i;
  logic       kick;
  logic       fault;
  logic [3:0] miss_mask;
  logic [7:0] rst_seen;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  wdt_service_ctrl #(.KICK_PERIOD(50), .KICK_WIDTH(2), .NTASK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .alive     (alive),
    .wdt_rst_i (wdt_rst_i),
    .kick      (kick),
    .fault     (fault),
    .miss_mask (miss_mask),
    .rst_seen  (rst_seen),
    .state_o   (state_o)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0] early;
    logic [3:0] late;
    logic       exp_kick;
    logic       exp_fault;
    logic [3:0] exp_miss;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; alive = '0; wdt_rst_i = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic start_run();
    en = 1'b1;
    step();
  endtask

  // Drives one 50-cycle window from counter 0; returns kick-high samples seen before the evaluation edge.
  task automatic run_window(input logic [3:0] early, input logic [3:0] late, output int khi);
    khi = 0;
    for (int k = 0; k < 50; k++) begin
      alive = ((k == 5) ? early : 4'b0) | ((k == 49) ? late : 4'b0);
      step();
      alive = '0;
      if (k < 49 && kick) khi++;
    end
  endtask

  initial begin
    int khi;
    int bad;
    int rises, hi, fcnt, last, cyc;
    logic prev;

    vecs[0] = '{early: 4'b1111, late: 4'b0000, exp_kick: 1'b1, exp_fault: 1'b0, exp_miss: 4'b0000};
    vecs[1] = '{early: 4'b1011, late: 4'b0000, exp_kick: 1'b0, exp_fault: 1'b1, exp_miss: 4'b0100};
    vecs[2] = '{early: 4'b0111, late: 4'b1000, exp_kick: 1'b1, exp_fault: 1'b0, exp_miss: 4'b0000};
    vecs[3] = '{early: 4'b0000, late: 4'b0000, exp_kick: 1'b0, exp_fault: 1'b1, exp_miss: 4'b1111};
    vecs[4] = '{early: 4'b0001, late: 4'b0110, exp_kick: 1'b0, exp_fault: 1'b1, exp_miss: 4'b1000};
    vecs[5] = '{early: 4'b0000, late: 4'b1111, exp_kick: 1'b1, exp_fault: 1'b0, exp_miss: 4'b0000};

    // reset state
    do_reset();
    check("rst_kick", kick, 0);
    check("rst_fault", fault, 0);
    check("rst_miss", miss_mask, 0);
    check("rst_seen", rst_seen, 0);
    check("rst_state", state_o, 0);

    // table-driven single windows
    for (int i = 0; i < 6; i++) begin
      do_reset();
      start_run();
      check($sformatf("vec%0d_state_run", i), state_o, 1);
      run_window(vecs[i].early, vecs[i].late, khi);
      check($sformatf("vec%0d_prekick", i), khi, 0);
      check($sformatf("vec%0d_kick1", i), kick, vecs[i].exp_kick);
      check($sformatf("vec%0d_fault", i), fault, vecs[i].exp_fault);
      check($sformatf("vec%0d_miss", i), miss_mask, vecs[i].exp_miss);
      step();
      check($sformatf("vec%0d_kick2", i), kick, vecs[i].exp_kick);
      step();
      check($sformatf("vec%0d_kick3", i), kick, 0);
    end

    // periodic kicks: width 2, rising every 50 cycles
    do_reset();
    start_run();
    rises = 0; hi = 0; fcnt = 0; last = 0; prev = 1'b0;
    for (int c = 0; c < 152; c++) begin
      alive = ((c % 50) == 10) ? 4'hF : 4'h0;
      step();
      alive = '0;
      cyc = c + 1;
      if (kick && !prev) begin
        if (rises == 0) check("per_first_rise", cyc, 50);
        else check("per_gap", cyc - last, 50);
        last = cyc;
        rises++;
      end
      if (kick) hi++;
      if (fault) fcnt++;
      prev = kick;
    end
    check("per_rises", rises, 3);
    check("per_high_cycles", hi, 6);
    check("per_fault_cycles", fcnt, 0);
    check("per_miss", miss_mask, 0);

    // HOLD: kicks withheld for 500 cycles, then en low one cycle recovers
    do_reset();
    start_run();
    run_window(4'b1011, 4'b0000, khi);
    check("hold_fault", fault, 1);
    check("hold_miss", miss_mask, 4'b0100);
    hi = 0; fcnt = 0;
    for (int c = 0; c < 500; c++) begin
      alive = ((c % 50) == 3) ? 4'hF : 4'h0;
      step();
      alive = '0;
      if (kick) hi++;
      if (!fault) fcnt++;
    end
    check("hold_kick_cycles", hi, 0);
    check("hold_fault_low_cycles", fcnt, 0);
    check("hold_miss_kept", miss_mask, 4'b0100);
    check("hold_state", state_o, 3);
    en = 1'b0;
    step();
    check("hold_exit_fault", fault, 0);
    check("hold_exit_miss", miss_mask, 0);
    check("hold_exit_state", state_o, 0);
    en = 1'b1;
    step();
    check("hold_rerun_state", state_o, 1);
    run_window(4'hF, 4'h0, khi);
    check("hold_rerun_prekick", khi, 0);
    check("hold_rerun_kick", kick, 1);

    // watchdog reset counting
    do_reset();
    start_run();
    for (int p = 0; p < 3; p++) begin
      wdt_rst_i = 1'b1;
      step();
      check($sformatf("wdt_pulse%0d_idle", p), state_o, 0);
      wdt_rst_i = 1'b0;
      step();
    end
    check("wdt_after3", rst_seen, 3);
    wdt_rst_i = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (state_o != 2'd0 || kick) bad++;
    end
    check("wdt_long_not_idle", bad, 0);
    check("wdt_long_once", rst_seen, 4);
    wdt_rst_i = 1'b0;
    step();
    check("wdt_released_run", state_o, 1);
    check("wdt_after_long", rst_seen, 4);
    en = 1'b0;
    step();
    step();
    check("wdt_en_keeps_count", rst_seen, 4);
    for (int p = 0; p < 300; p++) begin
      wdt_rst_i = 1'b1;
      step();
      wdt_rst_i = 1'b0;
      step();
    end
    check("wdt_saturate", rst_seen, 255);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("wdt_rst_clears", rst_seen, 0);

    // rst during the second kick cycle
    do_reset();
    en = 1'b1;
    wdt_rst_i = 1'b1;
    step();
    wdt_rst_i = 1'b0;
    step();
    check("mk_state_run", state_o, 1);
    check("mk_seen_one", rst_seen, 1);
    run_window(4'hF, 4'h0, khi);
    check("mk_kick1", kick, 1);
    step();
    check("mk_kick2", kick, 1);
    rst = 1'b1;
    step();
    check("mk_kick_dropped", kick, 0);
    check("mk_fault", fault, 0);
    check("mk_miss", miss_mask, 0);
    check("mk_rst_seen", rst_seen, 0);
    check("mk_state", state_o, 0);
    rst = 1'b0;
    en = 1'b0;
    hi = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (kick) hi++;
    end
    check("mk_no_residual", hi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
